data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-addressed, big-endian data memory behind a valid/ready request
//   port. Performs sized loads/stores (byte..doubleword) with sign or zero
//   extension, flags misaligned / out-of-range / unsupported accesses, and
//   returns a one-cycle response LATENCY cycles after acceptance.
//
// Parameters
//   DATA_W  : load/store datapath width, 32 or 64
//   DEPTH   : memory size in bytes, power of two, >= 8
//   LATENCY : cycles from acceptance to response, 1..4
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store, 0 = load
//   req_size              : 0 byte, 1 half, 2 word, 3 doubleword
//   req_unsigned          : zero-extend loads when 1
//   req_addr              : 64-bit byte address
//   req_wdata             : store data, right-justified
//   rsp_valid             : one-cycle response strobe
//   rsp_rdata / rsp_err   : load result / fault flag, held between responses
module data_mem_ctrl #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int unsigned NBYTES   = DATA_W / 8;
    localparam logic [1:0]  CNT_LAST = 2'(LATENCY > 1 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] pend_rdata;
    logic              pend_err;

    // 2-state storage: contents are zero from time zero and never reset.
    bit [7:0] mem [DEPTH];

    int unsigned       acc_bytes;
    logic [64:0]       acc_end;
    logic              fault;
    logic              accept;
    logic              do_store;
    logic              load_msb;
    logic [DATA_W-1:0] load_data;

    assign req_ready = (state != WAIT);
    assign accept    = req_valid && req_ready && !reset;
    assign do_store  = accept && req_write && !fault;

    // Fault detection; end address is computed in 65 bits so that addresses
    // near 2^64 cannot wrap back into range.
    always_comb begin
        acc_bytes = 32'd1 << req_size;
        acc_end   = {1'b0, req_addr} + 65'(acc_bytes);
        fault     = 1'b0;
        if ((req_addr & 64'(acc_bytes - 1)) != '0) fault = 1'b1;
        if (acc_end > 65'(DEPTH))                   fault = 1'b1;
        if (req_size == 2'd3 && DATA_W == 32)       fault = 1'b1;
    end

    // Load path: byte at req_addr lands in the most significant byte of the
    // field; bits above the field take the extension bit.
    always_comb begin
        load_data = '0;
        load_msb  = 1'b0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (i < acc_bytes) begin
                load_data[8*i +: 8] = mem[req_addr[AW-1:0] + AW'(acc_bytes - 1 - i)];
                if (i == acc_bytes - 1) load_msb = load_data[8*i + 7];
            end
        end
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (j >= 8 * acc_bytes) load_data[j] = load_msb & ~req_unsigned;
        end
        if (fault || req_write) load_data = '0;
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (i < acc_bytes)
                    mem[req_addr[AW-1:0] + AW'(acc_bytes - 1 - i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Response is captured at acceptance; with LATENCY > 1 it waits in
    // pend_* and is copied to the held outputs on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (lat_cnt == CNT_LAST) begin
                        state     <= RESP;
                        lat_cnt   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata;
                        rsp_err   <= pend_err;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data;
                            rsp_err   <= fault;
                        end else begin
                            state      <= WAIT;
                            lat_cnt    <= '0;
                            pend_rdata <= load_data;
                            pend_err   <= fault;
                        end
                    end
                end
            endcase
        end
    end

endmodule
